// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined WIDTH-bit add/sub with handshake, saturation and overflow counter
module addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    input  logic             SAT,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ans,
    output logic             cout,
    output logic             V,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Inputs seen by each carry segment: full operands, partial sum, carry-in, control bits.
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_s   [STAGES];
    logic             st_c   [STAGES];
    logic             st_v   [STAGES];
    logic             st_sat [STAGES];

    logic             stall;
    logic [WIDTH-1:0] fin_sum;
    logic             fin_c;

    logic             out_valid_q;
    logic [WIDTH-1:0] ans_q, ans_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    // The whole pipeline freezes only when a finished result is waiting on the consumer.
    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    // Segment 0 takes the raw operands; subtract is A + ~B with the +1 fed in as carry-in.
    assign st_a[0]   = A;
    assign st_b[0]   = SUB ? ~B : B;
    assign st_s[0]   = '0;
    assign st_c[0]   = SUB;
    assign st_v[0]   = in_valid;
    assign st_sat[0] = SAT;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG:0]     seg_sum;
        logic [WIDTH-1:0] sum_nxt;

        assign seg_sum = {1'b0, st_a[k][k*SEG +: SEG]} + {1'b0, st_b[k][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, st_c[k]};

        // Splice this segment's sum into the partial result carried along the pipe.
        always_comb begin
            sum_nxt                 = st_s[k];
            sum_nxt[k*SEG +: SEG]   = seg_sum[SEG-1:0];
        end

        if (k < LAST) begin : g_reg
            logic             v_q, c_q, sat_q;
            logic [WIDTH-1:0] a_q, b_q, s_q;

            // Stage register: advances whenever the output is not blocked; only valid is reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (!stall) begin
                    v_q   <= st_v[k];
                    c_q   <= seg_sum[SEG];
                    sat_q <= st_sat[k];
                    a_q   <= st_a[k];
                    b_q   <= st_b[k];
                    s_q   <= sum_nxt;
                end
            end

            assign st_a[k+1]   = a_q;
            assign st_b[k+1]   = b_q;
            assign st_s[k+1]   = s_q;
            assign st_c[k+1]   = c_q;
            assign st_v[k+1]   = v_q;
            assign st_sat[k+1] = sat_q;
        end else begin : g_last
            assign fin_sum = sum_nxt;
            assign fin_c   = seg_sum[SEG];
        end
    end

    // Final flags and the optional clamp; cout/V always report the unclamped result.
    always_comb begin
        cout_d = fin_c;
        v_d    = (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1]) &&
                 (fin_sum[WIDTH-1] != st_a[LAST][WIDTH-1]);
        ans_d  = fin_sum;
        if (st_sat[LAST] && v_d) begin
            ans_d = st_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // Overflow event counter: counts delivered results with V set, sticks at all-ones.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (out_valid_q && out_ready && v_q && (ovf_cnt_q != {CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        end
    end

    // Output register: loads only real results so ans/cout/V keep their last value otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ans_q       <= '0;
            cout_q      <= 1'b0;
            v_q         <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            if (!stall) begin
                out_valid_q <= st_v[LAST];
                if (st_v[LAST]) begin
                    ans_q  <= ans_d;
                    cout_q <= cout_d;
                    v_q    <= v_d;
                end
            end
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ans       = ans_q;
    assign cout      = cout_q;
    assign V         = v_q;
    assign ovf_count = ovf_cnt_q;

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined successor to the team's 32-bit combinational add/sub unit.
- Adds or subtracts two WIDTH-bit operands. The carry chain is split across STAGES register stages.
- Adds a valid/ready handshake, optional signed saturation and a saturating overflow-event counter.
- Sits in the datapath between the operand-issue logic and the result writeback.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of STAGES
STAGES, 4, pipeline depth = number of carry segments (1..WIDTH); each segment is WIDTH/STAGES bits
CNT_W, 16, width of the overflow event counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands present
in_ready  output  1  block accepts operands this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
SUB  input  1  0: A+B, 1: A-B (A + ~B + 1)
SAT  input  1  1: clamp result on signed overflow
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
ans  output  WIDTH  result
cout  output  1  carry out of MSB (subtract: 1 = no borrow)
V  output  1  signed overflow
ovf_count  output  CNT_W  number of accepted results with V=1, saturates at all-ones

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset (rst high at a rising edge) clears:
  - all stage valid bits, out_valid, ans, cout, V and ovf_count to 0;
  - in-flight operations, which are discarded.
  - rst has priority over every other event.
- Handshakes:
  - Transfer in: in_valid && in_ready at a rising edge.
  - Transfer out: out_valid && out_ready at a rising edge.
- Stall: stall = out_valid && !out_ready.
  - When stalled, the whole pipeline holds and in_ready = 0.
  - Otherwise in_ready = 1, including the cycle right after reset.
  - in_ready is combinational from out_valid/out_ready only; there is no in_valid→in_ready path.
- Pipeline, stage k (0..STAGES-1):
  - Adds segment k of A and of B-or-~B (bits k*SEG..k*SEG+SEG-1, SEG = WIDTH/STAGES), plus the carry from stage k-1.
  - Stage 0 carry-in = SUB.
  - The not-yet-summed upper segments and the SUB/SAT bits travel with the operation.
- Latency: STAGES cycles from the accepting edge to out_valid=1, with no stalls.
- Throughput: one operation per cycle.
- Bubbles (in_valid=0) propagate as invalid slots. Result order always equals acceptance order.
- Final stage:
  - sum = raw WIDTH-bit result.
  - cout = carry out of bit WIDTH-1.
  - V = (opA[MSB] == opB'[MSB]) && (sum[MSB] != opA[MSB]), where opB' = B or ~B.
  - If SAT && V: ans = 0x7F..F when opA[MSB]=0, else 0x80..0. Otherwise ans = sum.
  - cout and V are always the unsaturated values.
- ans, cout and V are registered.
  - They hold their value while out_valid=1 and out_ready=0.
  - They are don't-care when out_valid=0, but in practice they hold the last value.
- ovf_count:
  - Increments by 1 on each output transfer with V=1.
  - Holds at 2^CNT_W-1.
  - Is not cleared by anything except rst.
- STAGES=1: single registered stage, latency 1.
- STAGES=WIDTH: 1-bit segments.
- Wrap-around without SAT is modulo 2^WIDTH.
- Simultaneous output transfer and input acceptance in the same cycle is legal and required at full rate.

Test Plan:
1. WIDTH=32, STAGES=4: A=0x7FFFFFFF, B=1, SUB=0, SAT=0 → ans 0x80000000, cout 0, V 1, out_valid exactly 4 cycles after acceptance, ovf_count 1. Repeat with SAT=1 → ans 0x7FFFFFFF, V 1, ovf_count 2.
2. Subtract: A=5, B=5, SUB=1 → ans 0, cout 1, V 0. A=0, B=1, SUB=1 → ans 0xFFFFFFFF, cout 0, V 0. A=0x80000000, B=1, SUB=1, SAT=1 → ans 0x80000000, V 1.
3. Back-to-back stream of 5000 random ops with out_ready=1 → one result per cycle after the first 4; every ans/cout/V matches a reference model in order; ovf_count equals the model's overflow tally.
4. Backpressure: fill the pipeline, hold out_ready=0 for 10 cycles → in_ready 0, ans stable, no ops lost or duplicated. Release → results drain in order; random out_ready toggling gives no mismatches.
5. Reset mid-operation: assert rst for 1 cycle with 3 ops in flight → next cycle out_valid 0, ovf_count 0, in_ready 1; the dropped ops never appear; a new op completes after 4 cycles.
6. Counter saturation, CNT_W=2: 5 overflowing ops → ovf_count 3 and stays 3.
